// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative 32-bit multiply/divide unit for the EX stage.
// Handles MULT/MULTU/DIV/DIVU. Each operation takes 34 cycles: one to latch
// operands, 32 to iterate, one to apply signs and write HI/LO, then a
// one-cycle DONE. HI/LO are the architectural registers used by
// MFHI/MFLO/MTHI/MTLO.
// Ports:
//   clk, rst       clock (rising edge) / async active-low reset
//   start, op      launch; op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b           rs / rt operands
//   abort          cancel in-flight operation (flush)
//   wr_hi, wr_lo   MTHI/MTLO strobes, wdata is the write data
//   busy           CALC or FIX in progress (hazard-unit stall)
//   done           one-cycle pulse after HI/LO are written
//   hi, lo, result HI, LO and {HI,LO}
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        abort,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [63:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic        r_div;    // operation is a divide
  logic        r_sa;     // dividend / multiplicand was negative
  logic        r_sb;     // divisor / multiplier was negative
  logic        r_dz;     // divide by zero
  logic [31:0] r_opnd;   // |b|: multiplicand for multiply, divisor for divide
  logic [63:0] r_acc;    // multiply: {partial, multiplier}; divide: {rem, quotient}
  logic [31:0] r_hi, r_lo;
  logic        r_done;

  logic        w_accept;
  logic        w_signed, w_sa, w_sb;
  logic [31:0] w_abs_a, w_abs_b;
  logic [32:0] w_madd;
  logic [63:0] w_mul_nx;
  logic [32:0] w_shift, w_trial;
  logic [63:0] w_div_nx;
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem;
  logic [31:0] w_fix_hi, w_fix_lo;

  // Writes and launches are accepted only while not busy.
  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);

  // Magnitudes use plain unsigned negation, so |0x80000000| stays 0x80000000.
  assign w_signed = ~op[0];
  assign w_sa     = w_signed & a[31];
  assign w_sb     = w_signed & b[31];
  assign w_abs_a  = w_sa ? (32'd0 - a) : a;
  assign w_abs_b  = w_sb ? (32'd0 - b) : b;

  // Shift-add step: add multiplicand to upper half when the multiplier LSB
  // is set, then shift the whole accumulator right by one.
  assign w_madd   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_nx = {w_madd, r_acc[31:1]};

  // Restoring-division step: shift the next dividend bit into the remainder
  // and keep the subtraction only if it did not go negative.
  assign w_shift  = {r_acc[63:32], r_acc[31]};
  assign w_trial  = w_shift - {1'b0, r_opnd};
  assign w_div_nx = w_trial[32] ? {w_shift[31:0], r_acc[30:0], 1'b0}
                                : {w_trial[31:0], r_acc[30:0], 1'b1};

  // Sign fix-up. A zero divisor leaves rem=|a|, so hi=a falls out of the
  // remainder rule; only lo needs forcing to all-ones.
  assign w_prod   = (r_sa ^ r_sb) ? (64'd0 - r_acc) : r_acc;
  assign w_quo    = (r_sa ^ r_sb) ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  assign w_rem    = r_sa ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
  assign w_fix_hi = r_div ? w_rem : w_prod[63:32];
  assign w_fix_lo = r_div ? (r_dz ? 32'hFFFF_FFFF : w_quo) : w_prod[31:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_CALC;
      S_DONE: w_next = start ? S_CALC : S_IDLE;
      S_CALC: begin
        if (abort)               w_next = S_IDLE;
        else if (r_cnt == 5'd31) w_next = S_FIX;
      end
      S_FIX:  w_next = abort ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_div  <= 1'b0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_dz   <= 1'b0;
      r_opnd <= '0;
      r_acc  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // MTHI/MTLO land even on the same edge as a launch; FIX overwrites later.
      if (r_state == S_IDLE || r_state == S_DONE) begin
        if (wr_hi) r_hi <= wdata;
        if (wr_lo) r_lo <= wdata;
      end
      if (w_accept) begin
        r_cnt  <= '0;
        r_div  <= op[1];
        r_sa   <= w_sa;
        r_sb   <= w_sb;
        r_dz   <= op[1] && (b == 32'd0);
        r_opnd <= w_abs_b;
        r_acc  <= {32'd0, w_abs_a};
      end else if (r_state == S_CALC) begin
        if (abort) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 5'd1;
          r_acc <= r_div ? w_div_nx : w_mul_nx;
        end
      end else if (r_state == S_FIX && !abort) begin
        r_hi   <= w_fix_hi;
        r_lo   <= w_fix_lo;
        r_done <= 1'b1;
      end
    end
  end

  assign busy   = (r_state == S_CALC) || (r_state == S_FIX);
  assign done   = r_done;
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign result = {r_hi, r_lo};

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
  logic        clk, rst, start, abort, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .abort(abort), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  // Launch from the current cycle (idle or DONE) and follow it to E33.
  task automatic run_vec(input int idx, input vec_t v);
    logic bz_ok;
    bz_ok = 1'b1;
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      if (!busy || done) bz_ok = 1'b0;
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d_busy_window", idx), {63'd0, bz_ok}, 64'd1);
    chk($sformatf("v%0d_busy_done", idx), {62'd0, busy, done}, 64'd1);
    chk($sformatf("v%0d_hi", idx), {32'd0, hi}, {32'd0, v.hi});
    chk($sformatf("v%0d_lo", idx), {32'd0, lo}, {32'd0, v.lo});
    chk($sformatf("v%0d_result", idx), result, {v.hi, v.lo});
  endtask

  initial begin
    logic seen_done;
    vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[3] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[5] = '{2'b10, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF};
    vecs[6] = '{2'b11, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF};
    vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[9] = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};

    rst = 1'b0; start = 1'b0; abort = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    @(posedge clk); #1;
    chk("reset_outs", {busy, done, hi, lo}, 66'd0);
    chk("reset_result", result, 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Table runs back to back: each launch is sampled in the previous DONE.
    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);
    @(posedge clk); #1;
    chk("after_done_idle", {62'd0, busy, done}, 64'd0);

    // Launch and MTLO on the same edge: write lands, then result overwrites.
    op = 2'b01; a = 32'd5; b = 32'd5; start = 1'b1; wr_lo = 1'b1; wdata = 32'd12;
    @(posedge clk); #1;
    start = 1'b0; wr_lo = 1'b0;
    chk("same_edge_wr_lo", {32'd0, lo}, 64'd12);
    repeat (33) begin @(posedge clk); #1; end
    chk("same_edge_result", {31'd0, done, hi, lo}, {31'd0, 1'b1, 32'd0, 32'd25});

    // MTHI in IDLE.
    @(posedge clk); #1;
    wr_hi = 1'b1; wdata = 32'hAAAA0000;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    chk("mthi_idle", {32'd0, hi}, 64'hAAAA0000);

    // MULTU 5*5 with MTLO during CALC, aborted at E10.
    op = 2'b01; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;                          // E0
    start = 1'b0; wr_lo = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;                          // E1
    wr_lo = 1'b0;
    chk("wr_lo_busy_ignored", {32'd0, lo}, 64'd25);
    repeat (8) begin @(posedge clk); #1; end     // E9
    abort = 1'b1;
    @(posedge clk); #1;                          // E10
    abort = 1'b0;
    chk("abort_idle", {62'd0, busy, done}, 64'd0);
    seen_done = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen_done = 1'b1; end
    chk("abort_no_done", {63'd0, seen_done}, 64'd0);
    chk("abort_hilo_kept", result, {32'hAAAA0000, 32'd25});

    // Asynchronous reset in the middle of a DIVU.
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) begin @(posedge clk); end
    #2; rst = 1'b0; #1;
    chk("async_reset_outs", {busy, done, hi, lo}, 66'd0);
    chk("async_reset_result", result, 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // DIVU 9/3 with a second start in CALC that must be ignored.
    op = 2'b11; a = 32'd9; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      start = (k == 5);
      if (k == 5) begin a = 32'd100; b = 32'd7; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("ignored_start_done", {62'd0, busy, done}, 64'd1);
    chk("ignored_start_result", result, {32'd0, 32'd3});
    @(posedge clk); #1;
    chk("ignored_start_idle", {62'd0, busy, done}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative 32-bit multiply/divide unit for the EX stage. Accepts MULT/MULTU/DIV/DIVU operands from the ID/EX outputs. Computes a 64-bit {HI,LO} result over 34 cycles, and holds HI/LO as architectural state for MFHI/MFLO. Its busy output drives the hazard unit's stall, and its 64-bit result feeds the EX/MEM 64-bit ALU-result field.

## Interface
- No parameters; operand width fixed at 32, iteration count fixed at 32.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- start  in  1  launch operation (sampled on rising edge)
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  32  rs operand (multiplicand / dividend)
- b  in  32  rt operand (multiplier / divisor)
- abort  in  1  cancel in-flight operation (pipeline flush)
- wr_hi  in  1  MTHI write strobe
- wr_lo  in  1  MTLO write strobe
- wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in progress; hazard unit stalls IF/ID and bubbles ID/EX
- done  out  1  one-cycle pulse: HI/LO just updated
- hi  out  32  HI register
- lo  out  32  LO register
- result  out  64  {hi,lo}

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start: latch operands.
  - Signed ops store |a|, |b| and sign flags.
  - Go to CALC with cnt=0.
- IDLE/DONE without start: DONE→IDLE; IDLE stays.
- CALC, one bit per cycle, cnt++, →FIX when cnt reaches 31:
  - Multiply: shift-add, 64-bit accumulator.
  - Divide: restoring, 32-bit remainder, 32-bit quotient.
- FIX: apply signs, then write hi/lo and go to DONE.
  - Product: negated if sign(a)^sign(b).
  - Quotient: negated if sign(a)^sign(b).
  - Remainder: takes the sign of the dividend.
- DONE: done=1 for this cycle only.
- start while in CALC or FIX: ignored (no queue).
- abort in CALC or FIX:
  - Next state IDLE.
  - hi/lo unchanged, done not asserted.
  - abort has priority over the state's normal transition.
- wr_hi/wr_lo load wdata into hi/lo only in IDLE or DONE; ignored while busy.
  - Same-edge start and write: both take effect.
  - The write lands now; the operation overwrites hi/lo at FIX.
- Divide by zero (b==0), signed and unsigned: lo=32'hFFFFFFFF, hi=a.
  - Still takes full latency.
- Signed overflow, a=32'h80000000, b=32'hFFFFFFFF: lo=32'h80000000, hi=0.
- Arithmetic: all modulo 2^32 per half.
  - Magnitudes use an unsigned 32-bit path; |0x80000000| = 0x80000000.
- busy = (state==CALC || state==FIX).
- Reset (any state, asynchronous): state IDLE, cnt=0, hi=0, lo=0, busy=0, done=0, internal operand/accumulator registers 0.

## Timing
- Edge E0 samples start: busy=1 from just after E0.
- E1..E32: CALC iterations; state FIX after E32.
- E33: hi/lo updated; busy falls, done=1 until E34.
- Result visible on hi/lo/result 33 cycles after the start edge.
  - A dependent MFHI/MFLO may issue in the DONE cycle.
- A new start at E34 (sampled in DONE) is accepted: back-to-back issue every 34 cycles.
- abort sampled at edge Ek (1≤k≤33): IDLE after Ek; busy=0 the following cycle.
- Outputs are registered except busy and result (decoded from registers); no combinational input→output path.

## Test plan
- MULT a=32'hFFFFFFFD (-3), b=7, start at E0 -> busy high E0..E33, done pulse after E33, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001. DIVU 100/7 -> lo=14, hi=2.
- DIV a=-7 (32'hFFFFFFF9), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIV 32'h80000000/32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- DIV and DIVU with b=0, a=32'h12345678 -> lo=32'hFFFFFFFF, hi=32'h12345678 after 34 cycles.
- MTHI 32'hAAAA0000 in IDLE -> hi updated next edge.
  - Start MULTU 5*5, abort at E10 -> IDLE, no done, hi=32'hAAAA0000 unchanged.
  - wr_lo during CALC -> ignored.
- rst low at E15 of a DIVU -> all outputs 0 immediately.
  - After release, a fresh DIVU 9/3 -> lo=3, hi=0; start during busy ignored (result matches first operands).
